// File: rtl/z80_bus_seq.sv
// z80_bus_seq: Z80 pin-level bus-cycle sequencer for TV80-style cores.
// Turns one core request into registered strobes, address/data, refresh timing and read data.
module z80_bus_seq #(
  parameter int AW       = 16,
  parameter int M1_WAIT  = 0,
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 0,
  parameter int T2_WRITE = 1,
  parameter int REFRESH  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cen,
  input  logic          req,
  input  logic [1:0]    req_type,
  input  logic          req_write,
  input  logic          req_intack,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_wdata,
  input  logic [7:0]    i_reg,
  input  logic          r_load,
  input  logic [7:0]    r_val,
  output logic          ack,
  output logic [7:0]    rdata,
  output logic          busy,
  output logic [7:0]    r_reg,
  output logic [AW-1:0] A,
  output logic [7:0]    dout,
  input  logic [7:0]    di,
  input  logic          wait_n,
  output logic          m1_n,
  output logic          mreq_n,
  output logic          iorq_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          rfsh_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;

  localparam logic [1:0] TY_MRD = 2'b00;
  localparam logic [1:0] TY_MWR = 2'b01;
  localparam logic [1:0] TY_M1  = 2'b10;
  localparam logic [1:0] TY_IO  = 2'b11;

  function automatic logic [7:0] wait_count(input logic [1:0] ty, input logic intack);
    case (ty)
      TY_M1:   wait_count = 8'(M1_WAIT) + (intack ? 8'd2 : 8'd0);
      TY_IO:   wait_count = 8'(IO_WAIT) + 8'd1;
      default: wait_count = 8'(MEM_WAIT);
    endcase
  endfunction

  function automatic logic [AW-1:0] rfsh_addr(input logic [7:0] ir, input logic [7:0] rr);
    rfsh_addr = AW'({ir, rr});
  endfunction

  logic [2:0] state_r;
  logic [2:0] next_s;
  logic [1:0] typ_r;
  logic [1:0] typ_s;
  logic       intack_r;
  logic       intack_s;
  logic       write_r;
  logic       write_s;
  logic [7:0] wcnt_r;
  logic [7:0] wcnt_next_s;
  logic       final_s;
  logic       accept_s;
  logic       in_t2_t3_s;
  logic       in_t2_tw_s;
  logic       in_rfsh_s;
  logic       ack_s;
  logic       rfsh_entry_s;
  logic       m1_s, mreq_s, iorq_s, rd_s, wr_s, rfsh_s;

  // A request is only taken in IDLE or in the last T-state of the running cycle.
  assign final_s  = (state_r == S_IDLE) || (state_r == S_T4) ||
                    ((state_r == S_T3) && (typ_r != TY_M1));
  assign accept_s = final_s && req;

  assign typ_s    = accept_s ? req_type : typ_r;
  assign intack_s = accept_s ? ((req_type == TY_M1) && req_intack) : intack_r;
  assign write_s  = accept_s ? ((req_type == TY_MWR) || ((req_type == TY_IO) && req_write)) : write_r;

  // Next T-state and remaining programmed wait count.
  always_comb begin
    next_s      = S_IDLE;
    wcnt_next_s = wcnt_r;
    if (accept_s) begin
      next_s      = S_T1;
      wcnt_next_s = wait_count(req_type, req_intack);
    end else begin
      case (state_r)
        S_T1: next_s = S_T2;
        S_T2, S_TW: begin
          if (wcnt_r != 8'd0) begin
            next_s      = S_TW;
            wcnt_next_s = wcnt_r - 8'd1;
          end else if (!wait_n) begin
            next_s = S_TW;
          end else begin
            next_s = S_T3;
          end
        end
        S_T3:    next_s = (typ_r == TY_M1) ? S_T4 : S_IDLE;
        default: next_s = S_IDLE;
      endcase
    end
  end

  assign in_t2_t3_s   = (next_s == S_T2) || (next_s == S_TW) || (next_s == S_T3);
  assign in_t2_tw_s   = (next_s == S_T2) || (next_s == S_TW);
  assign in_rfsh_s    = (next_s == S_T3) || (next_s == S_T4);
  assign ack_s        = (next_s == S_T4) || ((next_s == S_T3) && (typ_s != TY_M1));
  assign rfsh_entry_s = (next_s == S_T3) && (typ_s == TY_M1);

  // Strobe levels for the T-state being entered, so the pins come straight from flops.
  always_comb begin
    m1_s   = 1'b1;
    mreq_s = 1'b1;
    iorq_s = 1'b1;
    rd_s   = 1'b1;
    wr_s   = 1'b1;
    rfsh_s = 1'b1;
    case (typ_s)
      TY_MRD: begin
        mreq_s = !in_t2_t3_s;
        rd_s   = !in_t2_t3_s;
      end
      TY_MWR: begin
        mreq_s = !in_t2_t3_s;
        wr_s   = (T2_WRITE != 32'sd0) ? !in_t2_t3_s : (next_s != S_T3);
      end
      TY_IO: begin
        iorq_s = !in_t2_t3_s;
        rd_s   = !(in_t2_t3_s && !write_s);
        wr_s   = !(in_t2_t3_s && write_s);
      end
      TY_M1: begin
        m1_s   = !((next_s == S_T1) || in_t2_tw_s);
        mreq_s = !((in_t2_tw_s && !intack_s) ||
                   ((next_s == S_T3) && (REFRESH != 32'sd0)));
        iorq_s = !(in_t2_tw_s && intack_s);
        rd_s   = !(in_t2_tw_s && !intack_s);
        rfsh_s = !in_rfsh_s;
      end
      default: begin
        m1_s = 1'b1;
      end
    endcase
  end

  // Sequencer state and latched cycle attributes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      typ_r    <= TY_MRD;
      intack_r <= 1'b0;
      write_r  <= 1'b0;
      wcnt_r   <= 8'd0;
    end else if (cen) begin
      state_r  <= next_s;
      typ_r    <= typ_s;
      intack_r <= intack_s;
      write_r  <= write_s;
      wcnt_r   <= wcnt_next_s;
    end
  end

  // Bus pins, handshake, address and data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m1_n   <= 1'b1;
      mreq_n <= 1'b1;
      iorq_n <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      rfsh_n <= 1'b1;
      ack    <= 1'b0;
      busy   <= 1'b0;
      A      <= '0;
      dout   <= 8'h00;
      rdata  <= 8'h00;
    end else if (cen) begin
      m1_n   <= m1_s;
      mreq_n <= mreq_s;
      iorq_n <= iorq_s;
      rd_n   <= rd_s;
      wr_n   <= wr_s;
      rfsh_n <= rfsh_s;
      ack    <= ack_s;
      busy   <= (next_s != S_IDLE);
      if (accept_s) begin
        A <= req_addr;
      end else if (rfsh_entry_s) begin
        A <= rfsh_addr(i_reg, r_reg);
      end
      if (accept_s && write_s) begin
        dout <= req_wdata;
      end
      // Read data, intack vector included, is taken on the edge into T3.
      if ((next_s == S_T3) && !write_s) begin
        rdata <= di;
      end
    end
  end

  // R counter: 7-bit increment after every refresh, bit 7 preserved; LD R,A wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg <= 8'h00;
    end else if (cen) begin
      if (r_load) begin
        r_reg <= r_val;
      end else if (state_r == S_T4) begin
        r_reg <= {r_reg[7], r_reg[6:0] + 7'd1};
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_seq.sv
// tb_z80_bus_seq: two parameterisations of z80_bus_seq driven in turn with directed and random
// cycles; expected pins come from per-position timing rules of each cycle type.
module tb_z80_bus_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        cen[2], req[2], req_write[2], req_intack[2], r_load[2], wait_n[2];
  logic [1:0]  req_type[2];
  logic [15:0] req_addr[2], A[2];
  logic [7:0]  req_wdata[2], i_reg[2], r_val[2], di[2], rdata[2], r_reg[2], dout[2];
  logic        ack[2], busy[2], m1_n[2], mreq_n[2], iorq_n[2], rd_n[2], wr_n[2], rfsh_n[2];

  logic [15:0] exp_a[2];
  logic [7:0]  exp_dout[2], exp_rdata[2], exp_r[2];
  logic        pend_inc[2];
  int          n_chk, n_err, cur_d;
  bit          rnd_rl;

  // Instance 0: defaults. Instance 1: waits everywhere, write only in T3, no refresh mreq_n.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    z80_bus_seq #(
      .AW(16), .M1_WAIT(g), .MEM_WAIT(2 * g), .IO_WAIT(g), .T2_WRITE(1 - g), .REFRESH(1 - g)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .cen(cen[g]), .req(req[g]), .req_type(req_type[g]),
      .req_write(req_write[g]), .req_intack(req_intack[g]), .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]), .i_reg(i_reg[g]), .r_load(r_load[g]), .r_val(r_val[g]),
      .ack(ack[g]), .rdata(rdata[g]), .busy(busy[g]), .r_reg(r_reg[g]), .A(A[g]),
      .dout(dout[g]), .di(di[g]), .wait_n(wait_n[g]), .m1_n(m1_n[g]), .mreq_n(mreq_n[g]),
      .iorq_n(iorq_n[g]), .rd_n(rd_n[g]), .wr_n(wr_n[g]), .rfsh_n(rfsh_n[g])
    );
  end

  function automatic int cfg_m1w(input int d);  return d;         endfunction
  function automatic int cfg_memw(input int d); return 2 * d;     endfunction
  function automatic int cfg_iow(input int d);  return d;         endfunction
  function automatic bit cfg_t2w(input int d);  return (d == 0);  endfunction
  function automatic bit cfg_rf(input int d);   return (d == 0);  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", tag, cur_d, $time, obs, exp_v);
    end
  endtask

  task automatic tick(input int d);
    @(posedge clk);
    if (cen[d]) begin
      if (r_load[d]) exp_r[d] = r_val[d];
      else if (pend_inc[d]) exp_r[d] = {exp_r[d][7], exp_r[d][6:0] + 7'd1};
      pend_inc[d] = 1'b0;
    end
    @(negedge clk);
  endtask

  // p = 0 means idle; p = 1 is T1, T2 is p = 2, w wait states, then T3 (and T4 for M1).
  task automatic check_pos(input int d, input logic [1:0] ty, input logic ia, input logic wr,
                           input int w, input int p);
    int l;
    logic e_m1, e_mreq, e_iorq, e_rd, e_wr, e_rf;
    l = (ty == 2'b10) ? 4 + w : 3 + w;
    e_m1 = 1'b1; e_mreq = 1'b1; e_iorq = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_rf = 1'b1;
    if (p > 0) begin
      case (ty)
        2'b00: begin e_mreq = !(p >= 2 && p <= 3 + w); e_rd = e_mreq; end
        2'b01: begin
          e_mreq = !(p >= 2 && p <= 3 + w);
          e_wr   = cfg_t2w(d) ? e_mreq : !(p == 3 + w);
        end
        2'b11: begin
          e_iorq = !(p >= 2 && p <= 3 + w);
          if (wr) e_wr = e_iorq; else e_rd = e_iorq;
        end
        default: begin
          e_m1   = !(p >= 1 && p <= 2 + w);
          e_rd   = !(p >= 2 && p <= 2 + w && !ia);
          e_iorq = !(p >= 2 && p <= 2 + w && ia);
          e_mreq = !((p >= 2 && p <= 2 + w && !ia) || (p == 3 + w && cfg_rf(d)));
          e_rf   = !(p >= 3 + w);
        end
      endcase
    end
    chk("m1_n",   32'(m1_n[d]),   32'(e_m1));
    chk("mreq_n", 32'(mreq_n[d]), 32'(e_mreq));
    chk("iorq_n", 32'(iorq_n[d]), 32'(e_iorq));
    chk("rd_n",   32'(rd_n[d]),   32'(e_rd));
    chk("wr_n",   32'(wr_n[d]),   32'(e_wr));
    chk("rfsh_n", 32'(rfsh_n[d]), 32'(e_rf));
    chk("ack",    32'(ack[d]),    32'(p == l && p > 0));
    chk("busy",   32'(busy[d]),   32'(p > 0));
    chk("A",      32'(A[d]),      32'(exp_a[d]));
    chk("dout",   32'(dout[d]),   32'(exp_dout[d]));
    chk("rdata",  32'(rdata[d]),  32'(exp_rdata[d]));
    chk("r_reg",  32'(r_reg[d]),  32'(exp_r[d]));
  endtask

  task automatic idle_tick(input int d, input logic rl, input logic [7:0] rv);
    cur_d = d;
    req[d] = 1'b0; r_load[d] = rl; r_val[d] = rv;
    wait_n[d] = 1'($urandom); di[d] = 8'($urandom); req_addr[d] = 16'($urandom);
    tick(d);
    r_load[d] = 1'b0;
    check_pos(d, 2'b00, 1'b0, 1'b0, 0, 0);
  endtask

  // Runs one cycle from the accept edge to its last T-state, leaving the DUT there.
  task automatic run_txn(input int d, input logic [1:0] ty, input logic ia_in, input logic wr_in,
                         input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] iv,
                         input logic [7:0] dv, input int ext, input int abort_at);
    logic ia, wr;
    int   n, w, l;
    bit   done;
    ia = (ty == 2'b10) && ia_in;
    wr = (ty == 2'b01) || (ty == 2'b11 && wr_in);
    n  = (ty == 2'b10) ? cfg_m1w(d) + (ia ? 2 : 0) : (ty == 2'b11) ? cfg_iow(d) + 1 : cfg_memw(d);
    w  = n + ext;
    l  = (ty == 2'b10) ? 4 + w : 3 + w;
    cur_d = d;
    req[d] = 1'b1; req_type[d] = ty; req_intack[d] = ia_in; req_write[d] = wr_in;
    req_addr[d] = addr; req_wdata[d] = wd; i_reg[d] = iv;
    wait_n[d] = 1'($urandom); di[d] = 8'($urandom);
    r_load[d] = rnd_rl && ($urandom_range(3) == 0); r_val[d] = 8'($urandom);
    tick(d);
    exp_a[d] = addr;
    if (wr) exp_dout[d] = wd;
    done = 1'b0;
    for (int p = 1; p <= l; p++) begin
      if (!done) begin
        check_pos(d, ty, ia, wr, w, p);
        if (p == abort_at) begin
          reset_n = 1'b0;
          #1;
          for (int k = 0; k < 2; k++) begin
            exp_a[k] = 16'h0; exp_dout[k] = 8'h0; exp_rdata[k] = 8'h0; exp_r[k] = 8'h0;
            pend_inc[k] = 1'b0;
          end
          check_pos(d, 2'b00, 1'b0, 1'b0, 0, 0);
          req[d] = 1'b0;
          @(negedge clk);
          reset_n = 1'b1;
          done = 1'b1;
        end else begin
          if ($urandom_range(3) == 0) begin
            cen[d] = 1'b0; req[d] = 1'($urandom); r_load[d] = 1'($urandom); r_val[d] = 8'($urandom);
            wait_n[d] = 1'($urandom); di[d] = 8'($urandom); req_addr[d] = 16'($urandom);
            tick(d);
            check_pos(d, ty, ia, wr, w, p);
            cen[d] = 1'b1; r_load[d] = 1'b0;
          end
          if (p == l) begin
            pend_inc[d] = (ty == 2'b10);
            done = 1'b1;
          end else begin
            req[d] = 1'($urandom); req_type[d] = 2'($urandom); req_addr[d] = 16'($urandom);
            req_wdata[d] = 8'($urandom); req_intack[d] = 1'($urandom); req_write[d] = 1'($urandom);
            r_load[d] = 1'b0;
            if (p + 1 >= 3 + n && p + 1 <= 2 + n + ext) wait_n[d] = 1'b0;
            else if (p + 1 == 3 + w) wait_n[d] = 1'b1;
            else wait_n[d] = 1'($urandom);
            di[d] = (p + 1 == 3 + w) ? dv : 8'($urandom);
            tick(d);
            if (p + 1 == 3 + w) begin
              if (!wr) exp_rdata[d] = dv;
              if (ty == 2'b10) exp_a[d] = {iv, exp_r[d]};
            end
          end
        end
      end
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; cur_d = 0; rnd_rl = 1'b0;
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cen[k] = 1'b1; req[k] = 1'b0; req_write[k] = 1'b0; req_intack[k] = 1'b0; r_load[k] = 1'b0;
      wait_n[k] = 1'b1; req_type[k] = 2'b00; req_addr[k] = 16'h0; req_wdata[k] = 8'h0;
      i_reg[k] = 8'h0; r_val[k] = 8'h0; di[k] = 8'h0;
      exp_a[k] = 16'h0; exp_dout[k] = 8'h0; exp_rdata[k] = 8'h0; exp_r[k] = 8'h0;
      pend_inc[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cur_d = k;
      check_pos(k, 2'b00, 1'b0, 1'b0, 0, 0);
    end
    reset_n = 1'b1;

    run_txn(0, 2'b00, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h00, 8'h5A, 0, 0);
    idle_tick(0, 1'b0, 8'h00);
    run_txn(1, 2'b01, 1'b0, 1'b0, 16'hBEEF, 8'hC3, 8'h00, 8'h00, 0, 0);
    idle_tick(1, 1'b0, 8'h00);
    run_txn(0, 2'b01, 1'b0, 1'b0, 16'hBEEF, 8'hC3, 8'h00, 8'h00, 0, 0);
    idle_tick(0, 1'b0, 8'h00);
    idle_tick(0, 1'b1, 8'h7F);
    run_txn(0, 2'b10, 1'b0, 1'b0, 16'h0100, 8'h00, 8'h3E, 8'hED, 0, 0);
    idle_tick(0, 1'b0, 8'h00);
    run_txn(1, 2'b11, 1'b0, 1'b0, 16'h00FE, 8'h00, 8'h00, 8'hA7, 3, 0);
    idle_tick(1, 1'b0, 8'h00);
    run_txn(0, 2'b10, 1'b1, 1'b0, 16'h0038, 8'h00, 8'h12, 8'hFF, 0, 0);
    run_txn(0, 2'b00, 1'b0, 1'b0, 16'h4000, 8'h00, 8'h00, 8'h3C, 0, 0);
    idle_tick(0, 1'b0, 8'h00);
    idle_tick(1, 1'b1, 8'h55);
    run_txn(1, 2'b01, 1'b0, 1'b0, 16'h8000, 8'h99, 8'h00, 8'h00, 0, 3);
    run_txn(1, 2'b00, 1'b0, 1'b0, 16'h2222, 8'h00, 8'h00, 8'h6B, 0, 0);
    idle_tick(1, 1'b0, 8'h00);

    rnd_rl = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 120; k++) begin
        run_txn(d, 2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom), int'($urandom_range(3)), 0);
        if ($urandom_range(1) == 0)
          idle_tick(d, 1'($urandom_range(3) == 0), 8'($urandom));
      end
      idle_tick(d, 1'b0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
